// File: rtl/reg_alu_top.sv
`default_nettype none
// ============================================================================
// Module      : reg_alu_top
// Description : Execute datapath of the RISC core prototype. Sixteen 32-bit
//               general registers with two combinational read ports (Rs, Rt)
//               and one write port (Rd) fed by an 8-operation ALU. Each 0->1
//               transition of `execute` performs exactly one
//               R[Rd] <= R[Rs] op R[Rt]. The register selected by Rd is shown
//               16 bits at a time on display_output for board observation.
//
// Ports       : clk                 - system clock, rising-edge active
//               rst                 - synchronous active-high reset
//               execute             - operation request (level, edge-detected)
//               ALU_Operation[2:0]  - ALU opcode
//               Rs[3:0], Rt[3:0]    - source register indices
//               Rd[3:0]             - destination / displayed register index
//               DFT_Display_Select  - 0: R[Rd][15:0], 1: R[Rd][31:16]
//               display_output[15:0]- combinational view of R[Rd]
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_alu_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        execute,
    input  logic [2:0]  ALU_Operation,
    input  logic [3:0]  Rs,
    input  logic [3:0]  Rt,
    input  logic [3:0]  Rd,
    input  logic        DFT_Display_Select,
    output logic [15:0] display_output
);

    localparam int unsigned c_NUM_REGS = 16;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLL = 3'b101;
    localparam logic [2:0] c_OP_SRL = 3'b110;
    localparam logic [2:0] c_OP_SRA = 3'b111;

    logic [31:0] r_regs [c_NUM_REGS];
    logic        r_execute_q;

    // Read-port nets keep these names so they can be probed hierarchically.
    logic [31:0] rsOut;
    logic [31:0] rtOut;
    logic [31:0] w_alu_result;
    logic [31:0] w_rd_val;
    logic        w_we;

    assign rsOut    = r_regs[Rs];
    assign rtOut    = r_regs[Rt];
    assign w_rd_val = r_regs[Rd];

    // One write per rising edge of execute, however long it is held.
    assign w_we = execute & ~r_execute_q;

    // Shift amount is only rtOut[0]; upper bits are deliberately ignored.
    always_comb begin
        w_alu_result = 32'd0;
        case (ALU_Operation)
            c_OP_ADD: w_alu_result = rsOut + rtOut;
            c_OP_SUB: w_alu_result = rsOut - rtOut;
            c_OP_AND: w_alu_result = rsOut & rtOut;
            c_OP_OR:  w_alu_result = rsOut | rtOut;
            c_OP_XOR: w_alu_result = rsOut ^ rtOut;
            c_OP_SLL: w_alu_result = rsOut << rtOut[0];
            c_OP_SRL: w_alu_result = rsOut >> rtOut[0];
            c_OP_SRA: w_alu_result = $unsigned($signed(rsOut) >>> rtOut[0]);
            default:  w_alu_result = 32'd0;
        endcase
    end

    // execute_q tracks execute even during reset, so a level held high across
    // reset release is not seen as a new request.
    always_ff @(posedge clk) begin
        r_execute_q <= execute;
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= 32'(i);
            end
        end else if (w_we) begin
            r_regs[Rd] <= w_alu_result;
        end
    end

    assign display_output = DFT_Display_Select ? w_rd_val[31:16] : w_rd_val[15:0];

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_alu_top
// Description : Self-checking bench for reg_alu_top. Directed vector table
//               with constant expected values, hand-written multi-cycle
//               sequences around reset, and randomized operations compared
//               against an arithmetic reference model of the register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_alu_top;

    logic        clk;
    logic        rst;
    logic        execute;
    logic [2:0]  ALU_Operation;
    logic [3:0]  Rs;
    logic [3:0]  Rt;
    logic [3:0]  Rd;
    logic        DFT_Display_Select;
    logic [15:0] display_output;

    int n_tests;
    int n_fail;

    logic [31:0] model_regs [16];

    reg_alu_top dut (
        .clk                (clk),
        .rst                (rst),
        .execute            (execute),
        .ALU_Operation      (ALU_Operation),
        .Rs                 (Rs),
        .Rt                 (Rt),
        .Rd                 (Rd),
        .DFT_Display_Select (DFT_Display_Select),
        .display_output     (display_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [2:0]  op;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    // Reference ALU written from the operation definitions with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] half;
        half = a / 2;
        case (op)
            3'd0: return a + b;
            3'd1: return a + (~b) + 32'd1;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (b % 2 == 1) ? a * 2 : a;
            3'd6: return (b % 2 == 1) ? half : a;
            default: return (b % 2 == 1) ? (a >= 32'h8000_0000 ? half + 32'h8000_0000 : half) : a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 32'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        execute = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Reads R[r] through the display port, both halves, with no clock in between.
    task automatic read_reg(input logic [3:0] r, output logic [31:0] val);
        logic [15:0] lo;
        Rd = r;
        DFT_Display_Select = 1'b0;
        #1 lo = display_output;
        DFT_Display_Select = 1'b1;
        #1 val = {display_output, lo};
    endtask

    task automatic do_op(input logic [2:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input int hold);
        logic [31:0] res;
        @(negedge clk);
        ALU_Operation = op;
        Rs = rs;
        Rt = rt;
        Rd = rd;
        execute = 1'b1;
        res = ref_alu(op, model_regs[rs], model_regs[rt]);
        repeat (hold) @(negedge clk);
        execute = 1'b0;
        model_regs[rd] = res;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        execute = 1'b0;
        ALU_Operation = 3'd0;
        Rs = 4'd0;
        Rt = 4'd0;
        Rd = 4'd0;
        DFT_Display_Select = 1'b0;

        vecs[0]  = '{1'b1, 3'd0, 4'd0,  4'd1,  4'd15, 1, 32'h0000_0001};
        vecs[1]  = '{1'b0, 3'd1, 4'd1,  4'd5,  4'd9,  1, 32'hFFFF_FFFC};
        vecs[2]  = '{1'b1, 3'd2, 4'd12, 4'd10, 4'd6,  1, 32'h0000_0008};
        vecs[3]  = '{1'b0, 3'd3, 4'd8,  4'd4,  4'd9,  1, 32'h0000_000C};
        vecs[4]  = '{1'b0, 3'd4, 4'd15, 4'd15, 4'd11, 1, 32'h0000_0000};
        vecs[5]  = '{1'b1, 3'd5, 4'd7,  4'd3,  4'd13, 1, 32'h0000_000E};
        vecs[6]  = '{1'b0, 3'd5, 4'd4,  4'd2,  4'd12, 1, 32'h0000_0004};
        vecs[7]  = '{1'b0, 3'd6, 4'd15, 4'd1,  4'd11, 1, 32'h0000_0007};
        vecs[8]  = '{1'b1, 3'd1, 4'd1,  4'd15, 4'd10, 1, 32'hFFFF_FFF2};
        vecs[9]  = '{1'b0, 3'd7, 4'd10, 4'd1,  4'd10, 1, 32'hFFFF_FFF9};
        vecs[10] = '{1'b0, 3'd7, 4'd14, 4'd1,  4'd13, 1, 32'h0000_0007};
        vecs[11] = '{1'b1, 3'd0, 4'd1,  4'd2,  4'd0,  1, 32'h0000_0003};
        vecs[12] = '{1'b0, 3'd0, 4'd0,  4'd3,  4'd1,  1, 32'h0000_0006};
        vecs[13] = '{1'b0, 3'd0, 4'd1,  4'd4,  4'd2,  1, 32'h0000_000A};
        vecs[14] = '{1'b0, 3'd0, 4'd2,  4'd5,  4'd3,  1, 32'h0000_000F};
        vecs[15] = '{1'b0, 3'd0, 4'd10, 4'd1,  4'd10, 3, 32'h0000_0010};
        vecs[16] = '{1'b0, 3'd0, 4'd10, 4'd10, 4'd10, 2, 32'h0000_0020};
        vecs[17] = '{1'b0, 3'd1, 4'd10, 4'd5,  4'd10, 4, 32'h0000_001B};
        vecs[18] = '{1'b0, 3'd6, 4'd12, 4'd3,  4'd12, 2, 32'h0000_0006};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset state seen through the display port: low half = index, high = 0.
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            check($sformatf("reset_R%0d", i), v, 32'(i));
        end

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].do_rst) do_reset();
            do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].hold);
            read_reg(vecs[i].rd, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
            check($sformatf("vec%0d_model", i), v, model_regs[vecs[i].rd]);
        end

        // Display halves individually for the SUB result R9 = 0xFFFFFFFC.
        do_reset();
        do_op(3'd1, 4'd1, 4'd5, 4'd9, 1);
        Rd = 4'd9;
        DFT_Display_Select = 1'b0;
        #1 check("disp_lo_R9", 32'(display_output), 32'h0000_FFFC);
        DFT_Display_Select = 1'b1;
        #1 check("disp_hi_R9", 32'(display_output), 32'h0000_FFFF);
        Rd = 4'd7;
        #1 check("disp_hi_R7", 32'(display_output), 32'h0000_0000);

        // execute held high through reset release: no write afterwards.
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        ALU_Operation = 3'd0;
        Rs = 4'd1;
        Rt = 4'd2;
        Rd = 4'd5;
        execute = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        read_reg(4'd5, v);
        check("exec_through_reset_R5", v, 32'd5);
        // A fresh 0->1 transition is then accepted.
        execute = 1'b0;
        @(negedge clk);
        Rd = 4'd5;
        execute = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        @(negedge clk);
        read_reg(4'd5, v);
        check("fresh_edge_after_reset_R5", v, 32'd3);

        // Reset asserted while a write is requested: reset wins.
        @(negedge clk);
        Rs = 4'd3; Rt = 4'd4; Rd = 4'd6; ALU_Operation = 3'd0;
        rst = 1'b1;
        execute = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        execute = 1'b0;
        @(negedge clk);
        model_reset();
        read_reg(4'd6, v);
        check("reset_priority_R6", v, 32'd6);
        read_reg(4'd5, v);
        check("reset_reload_R5", v, 32'd5);

        // Randomized operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [2:0] op;
            logic [3:0] a, b, d;
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            do_op(op, a, b, d, int'($urandom_range(1, 3)));
            read_reg(d, v);
            check($sformatf("rand%0d_op%0d_R%0d", n, op, d), v, model_regs[d]);
            if (n % 10 == 0) begin
                Rs = 4'($urandom_range(0, 15));
                Rt = 4'($urandom_range(0, 15));
                #1;
                check($sformatf("rand%0d_rsOut", n), dut.rsOut, model_regs[Rs]);
                check($sformatf("rand%0d_rtOut", n), dut.rtOut, model_regs[Rt]);
            end
        end

        // Final sweep of the whole bank.
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            check($sformatf("final_R%0d", i), v, model_regs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
